// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: routes each access to data memory, one of NCH peripheral
// channels or a fault, runs the req/gnt/rvalid handshake and formats WB results.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned halfword/word accesses fault).
module mem_stage_lsu #(
  parameter int          DMEM_AW        = 10,
  parameter int          NCH            = 2,
  parameter logic [31:0] PERIPH_BASE    = 32'h0010_0000,
  parameter int          PERIPH_SPAN_LG = 20
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ex_valid_i,
  input  logic [3:0]                ex_dmem_type_i,
  input  logic [31:0]               ex_addr_i,
  input  logic [31:0]               ex_wdata_i,
  input  logic [31:0]               ex_result_i,
  input  logic [4:0]                ex_rd_idx_i,
  input  logic                      ex_reg_write_en_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      dmem_req_o,
  input  logic                      dmem_gnt_i,
  output logic                      dmem_we_o,
  output logic [DMEM_AW-1:0]        dmem_addr_o,
  output logic [3:0]                dmem_be_o,
  output logic [31:0]               dmem_wdata_o,
  input  logic                      dmem_rvalid_i,
  input  logic [31:0]               dmem_rdata_i,
  output logic [NCH-1:0]            periph_req_o,
  input  logic [NCH-1:0]            periph_gnt_i,
  input  logic [NCH-1:0]            periph_rvalid_i,
  input  logic [32*NCH-1:0]         periph_rdata_i,
  output logic                      periph_we_o,
  output logic [3:0]                periph_be_o,
  output logic [31:0]               periph_wdata_o,
  output logic [PERIPH_SPAN_LG-1:0] periph_addr_o,
  output logic                      wb_valid_o,
  output logic [4:0]                wb_rd_idx_o,
  output logic                      wb_reg_write_en_o,
  output logic [31:0]               wb_data_o,
  output logic                      fault_o,
  output logic [31:0]               fault_addr_o
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  // DMEM_* access encoding shared with the decode stage.
  localparam logic [3:0] DMEM_NO  = 4'd0, DMEM_LB  = 4'd1, DMEM_LH  = 4'd2,
                         DMEM_LW  = 4'd3, DMEM_LBU = 4'd4, DMEM_LHU = 4'd5,
                         DMEM_SB  = 4'd6, DMEM_SH  = 4'd7, DMEM_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cap_type;
  logic [31:0] cap_addr, cap_wdata;
  logic [4:0]  cap_rd;
  logic        cap_rwe, killed_q;

  // Once an access leaves IDLE everything is driven from the captured copy.
  logic        idle;
  logic [3:0]  cur_type;
  logic [31:0] cur_addr, cur_wdata;
  assign idle      = (state_q == S_IDLE);
  assign cur_type  = idle ? ex_dmem_type_i : cap_type;
  assign cur_addr  = idle ? ex_addr_i      : cap_addr;
  assign cur_wdata = idle ? ex_wdata_i     : cap_wdata;

  logic is_load, is_store, is_mem, is_byte, is_half;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_load  = cur_type inside {DMEM_LB, DMEM_LH, DMEM_LW, DMEM_LBU, DMEM_LHU};
    is_store = cur_type inside {DMEM_SB, DMEM_SH, DMEM_SW};
    is_byte  = cur_type inside {DMEM_LB, DMEM_LBU, DMEM_SB};
    is_half  = cur_type inside {DMEM_LH, DMEM_LHU, DMEM_SH};
  end
  assign is_mem = is_load || is_store;

  // Target decode; data memory is checked first so it wins any overlap.
  logic [31:0]     periph_off, ch_full;
  logic [CH_W-1:0] ch;
  logic            hit_dmem, hit_periph, misalign;
  assign hit_dmem   = (cur_addr >> (DMEM_AW + 2)) == 32'd0;
  assign periph_off = cur_addr - PERIPH_BASE;
  assign ch_full    = periph_off >> PERIPH_SPAN_LG;
  assign hit_periph = !hit_dmem && (cur_addr >= PERIPH_BASE) && (ch_full < 32'(NCH));
  assign ch         = ch_full[CH_W-1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((cur_type inside {DMEM_LH, DMEM_LHU, DMEM_SH}) && cur_addr[0]) ||
                    ((cur_type inside {DMEM_LW, DMEM_SW}) && (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = cur_wdata;
    if (is_byte) begin
      lane_be    = 4'b0001 << cur_addr[1:0];
      lane_wdata = {4{cur_wdata[7:0]}};
    end else if (is_half) begin
      lane_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{cur_wdata[15:0]}};
    end
  end

  logic        gnt_sel, rvalid_sel;
  logic [31:0] rdata_sel;
  assign gnt_sel    = hit_dmem ? dmem_gnt_i    : periph_gnt_i[ch];
  assign rvalid_sel = hit_dmem ? dmem_rvalid_i : periph_rvalid_i[ch];
  assign rdata_sel  = hit_dmem ? dmem_rdata_i  : periph_rdata_i[{ch, 5'b0} +: 32];

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  always_comb begin
    ld_byte = rdata_sel[{cur_addr[1:0], 3'b000} +: 8];
    ld_half = cur_addr[1] ? rdata_sel[31:16] : rdata_sel[15:0];
    case (cur_type)
      DMEM_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      DMEM_LBU: ld_data = {24'b0, ld_byte};
      DMEM_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      DMEM_LHU: ld_data = {16'b0, ld_half};
      default:  ld_data = rdata_sel;
    endcase
  end

  logic access_ok, issue_idle, fault_now, req_active, wb_load;
  assign access_ok  = (hit_dmem || hit_periph) && !misalign;
  assign issue_idle = resetn && idle && ex_valid_i && is_mem && !flush_i && access_ok;
  assign fault_now  = resetn && idle && ex_valid_i && is_mem && !flush_i && !access_ok;
  assign req_active = issue_idle || (resetn && (state_q == S_REQ) && !flush_i);
  assign wb_load    = (state_q == S_WAIT) && rvalid_sel && !killed_q && !flush_i;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (issue_idle) state_d = !gnt_sel ? S_REQ : (is_load ? S_WAIT : S_IDLE);
      S_REQ: begin
        if (flush_i)      state_d = S_IDLE;
        else if (gnt_sel) state_d = is_load ? S_WAIT : S_IDLE;
      end
      S_WAIT: if (rvalid_sel) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_req_o     = 1'b0;
    dmem_we_o      = 1'b0;
    dmem_addr_o    = '0;
    dmem_be_o      = 4'b0;
    dmem_wdata_o   = 32'b0;
    periph_req_o   = '0;
    periph_we_o    = 1'b0;
    periph_be_o    = 4'b0;
    periph_wdata_o = 32'b0;
    periph_addr_o  = '0;
    stall_o        = resetn && ((issue_idle && !gnt_sel) || !idle);
    if (req_active && hit_dmem) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = is_store;
      dmem_addr_o  = cur_addr[DMEM_AW+1:2];
      dmem_be_o    = lane_be;
      dmem_wdata_o = is_store ? lane_wdata : 32'b0;
    end else if (req_active && hit_periph) begin
      periph_req_o[ch] = 1'b1;
      periph_we_o      = is_store;
      periph_addr_o    = periph_off[PERIPH_SPAN_LG-1:0];
      periph_be_o      = lane_be;
      periph_wdata_o   = is_store ? lane_wdata : 32'b0;
    end
  end

  // NOTE: the capture registers need no reset; they are only read after an issue loads them.
  always_ff @(posedge clk) begin
    if (issue_idle) begin
      cap_type  <= ex_dmem_type_i;
      cap_addr  <= ex_addr_i;
      cap_wdata <= ex_wdata_i;
      cap_rd    <= ex_rd_idx_i;
      cap_rwe   <= ex_reg_write_en_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)                            killed_q <= 1'b0;
    else if (issue_idle)                    killed_q <= 1'b0;
    else if ((state_q == S_WAIT) && flush_i) killed_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid_o        <= 1'b0;
      wb_rd_idx_o       <= 5'b0;
      wb_reg_write_en_o <= 1'b0;
      wb_data_o         <= 32'b0;
      fault_o           <= 1'b0;
      fault_addr_o      <= 32'b0;
    end else begin
      wb_valid_o        <= 1'b0;
      wb_rd_idx_o       <= 5'b0;
      wb_reg_write_en_o <= 1'b0;
      wb_data_o         <= 32'b0;
      fault_o           <= fault_now;
      if (fault_now) fault_addr_o <= ex_addr_i;
      if (idle && ex_valid_i && !flush_i && (ex_dmem_type_i == DMEM_NO)) begin
        wb_valid_o        <= 1'b1;
        wb_rd_idx_o       <= ex_rd_idx_i;
        wb_reg_write_en_o <= ex_reg_write_en_i;
        wb_data_o         <= ex_result_i;
      end else if (issue_idle && gnt_sel && is_store) begin
        wb_valid_o  <= 1'b1;
        wb_rd_idx_o <= ex_rd_idx_i;
        wb_data_o   <= ex_result_i;
      end else if (wb_load) begin
        wb_valid_o        <= 1'b1;
        wb_rd_idx_o       <= cap_rd;
        wb_reg_write_en_o <= cap_rwe;
        wb_data_o         <= ld_data;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu: stores, loads, peripheral handshake,
// faults, flush and reset; expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_mem_stage_lsu;
  localparam logic [3:0] DMEM_NO  = 4'd0, DMEM_LB  = 4'd1, DMEM_LH  = 4'd2,
                         DMEM_LW  = 4'd3, DMEM_LBU = 4'd4, DMEM_LHU = 4'd5,
                         DMEM_SB  = 4'd6, DMEM_SH  = 4'd7, DMEM_SW  = 4'd8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, ex_rwe, flush;
  logic [3:0]  ex_type;
  logic [31:0] ex_addr, ex_wdata, ex_result;
  logic [4:0]  ex_rd;
  logic        stall, dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
  logic [9:0]  dmem_addr;
  logic [3:0]  dmem_be, periph_be;
  logic [31:0] dmem_wdata, dmem_rdata, periph_wdata;
  logic [1:0]  periph_req, periph_gnt, periph_rvalid;
  logic [63:0] periph_rdata;
  logic        periph_we;
  logic [19:0] periph_addr;
  logic        wb_valid, wb_rwe, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, fault_addr;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .resetn(resetn),
    .ex_valid_i(ex_valid), .ex_dmem_type_i(ex_type), .ex_addr_i(ex_addr),
    .ex_wdata_i(ex_wdata), .ex_result_i(ex_result), .ex_rd_idx_i(ex_rd),
    .ex_reg_write_en_i(ex_rwe), .flush_i(flush), .stall_o(stall),
    .dmem_req_o(dmem_req), .dmem_gnt_i(dmem_gnt), .dmem_we_o(dmem_we),
    .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
    .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .periph_req_o(periph_req), .periph_gnt_i(periph_gnt), .periph_rvalid_i(periph_rvalid),
    .periph_rdata_i(periph_rdata), .periph_we_o(periph_we), .periph_be_o(periph_be),
    .periph_wdata_o(periph_wdata), .periph_addr_o(periph_addr),
    .wb_valid_o(wb_valid), .wb_rd_idx_o(wb_rd), .wb_reg_write_en_o(wb_rwe),
    .wb_data_o(wb_data), .fault_o(fault), .fault_addr_o(fault_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] res, input logic [4:0] rd, input logic rwe);
    ex_valid = 1'b1; ex_type = t; ex_addr = a; ex_wdata = wd;
    ex_result = res; ex_rd = rd; ex_rwe = rwe;
  endtask

  task automatic ex_idle();
    ex_valid = 1'b0; ex_type = DMEM_NO; ex_addr = 32'h0; ex_wdata = 32'h0;
    ex_result = 32'h0; ex_rd = 5'd0; ex_rwe = 1'b0;
  endtask

  // Data-memory load with immediate grant and one-cycle response.
  task automatic dmem_load(input string tag, input logic [3:0] t, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp);
    set_op(t, a, 32'h0, 32'h0, 5'd9, 1'b1);
    dmem_gnt = 1'b1;
    #1;
    check({tag, " req"}, dmem_req, 1);
    check({tag, " issue_stall"}, stall, 0);
    tick();
    ex_idle();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = word;
    #1;
    check({tag, " wait_stall"}, stall, 1);
    check({tag, " early_wb"}, wb_valid, 0);
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    check({tag, " wb_valid"}, wb_valid, 1);
    check({tag, " wb_data"}, wb_data, exp);
    check({tag, " wb_rd"}, wb_rd, 9);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0;
    ex_idle();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    periph_gnt = 2'b00; periph_rvalid = 2'b00; periph_rdata = 64'h0;
    tick(); tick();
    check("rst stall", stall, 0);
    check("rst dmem_req", dmem_req, 0);
    check("rst periph_req", periph_req, 0);
    check("rst wb_valid", wb_valid, 0);
    check("rst wb_data", wb_data, 0);
    check("rst fault", fault, 0);
    check("rst fault_addr", fault_addr, 0);

    // Stray response while idle.
    resetn = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    check("stray wb_valid", wb_valid, 0);
    check("stray stall", stall, 0);

    // SW 0xDEADBEEF to 0x10, immediate grant.
    set_op(DMEM_SW, 32'h10, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 1'b1);
    dmem_gnt = 1'b1;
    #1;
    check("sw req", dmem_req, 1);
    check("sw we", dmem_we, 1);
    check("sw addr", dmem_addr, 4);
    check("sw be", dmem_be, 4'b1111);
    check("sw wdata", dmem_wdata, 32'hDEAD_BEEF);
    check("sw stall", stall, 0);
    tick();
    ex_idle();
    dmem_gnt = 1'b0;
    check("sw wb_valid", wb_valid, 1);
    check("sw wb_rwe", wb_rwe, 0);
    check("sw wb_data", wb_data, 32'h1234_5678);

    // Byte and halfword store lanes.
    set_op(DMEM_SB, 32'h13, 32'h0000_00AB, 32'h0, 5'd0, 1'b0);
    dmem_gnt = 1'b1;
    #1;
    check("sb be", dmem_be, 4'b1000);
    check("sb wdata", dmem_wdata, 32'hABAB_ABAB);
    tick();
    set_op(DMEM_SH, 32'h12, 32'h0000_1234, 32'h0, 5'd0, 1'b0);
    #1;
    check("sh be", dmem_be, 4'b1100);
    check("sh wdata", dmem_wdata, 32'h1234_1234);
    check("sh addr", dmem_addr, 4);
    tick();
    ex_idle();
    dmem_gnt = 1'b0;

    // Load extension from word 0x80FF_0000.
    dmem_load("lb", DMEM_LB, 32'h13, 32'h80FF_0000, 32'hFFFF_FF80);
    dmem_load("lbu", DMEM_LBU, 32'h13, 32'h80FF_0000, 32'h0000_0080);
    dmem_load("lh", DMEM_LH, 32'h12, 32'h80FF_0000, 32'hFFFF_80FF);
    dmem_load("lhu", DMEM_LHU, 32'h12, 32'h80FF_0000, 32'h0000_80FF);

    // Non-memory op passes its result through.
    set_op(DMEM_NO, 32'h0, 32'h0, 32'h0000_55AA, 5'd7, 1'b1);
    #1;
    check("alu stall", stall, 0);
    check("alu req", dmem_req, 0);
    tick();
    ex_idle();
    check("alu wb_valid", wb_valid, 1);
    check("alu wb_rd", wb_rd, 7);
    check("alu wb_rwe", wb_rwe, 1);
    check("alu wb_data", wb_data, 32'h0000_55AA);

    // Channel 1 load: grant three cycles late, response two cycles after grant.
    set_op(DMEM_LW, 32'h0020_0008, 32'h0, 32'h0, 5'd11, 1'b1);
    #1;
    check("ch1 req", periph_req, 2'b10);
    check("ch1 addr", periph_addr, 8);
    check("ch1 we", periph_we, 0);
    check("ch1 dmem_req", dmem_req, 0);
    check("ch1 stall c0", stall, 1);
    tick();
    ex_idle();
    #1;
    check("ch1 held req", periph_req, 2'b10);
    check("ch1 held addr", periph_addr, 8);
    check("ch1 stall c1", stall, 1);
    tick();
    check("ch1 stall c2", stall, 1);
    tick();
    periph_gnt = 2'b10;
    #1;
    check("ch1 req at gnt", periph_req, 2'b10);
    tick();
    periph_gnt = 2'b00; periph_rvalid = 2'b01; periph_rdata = {32'h0, 32'h1111_1111};
    #1;
    check("ch1 wait req", periph_req, 0);
    check("ch1 stall c4", stall, 1);
    tick();
    periph_rvalid = 2'b10; periph_rdata = {32'hCAFE_F00D, 32'h1111_1111};
    #1;
    check("ch1 other-ch ignored", wb_valid, 0);
    check("ch1 stall at rvalid", stall, 1);
    tick();
    periph_rvalid = 2'b00; periph_rdata = 64'h0;
    check("ch1 wb_valid", wb_valid, 1);
    check("ch1 wb_data", wb_data, 32'hCAFE_F00D);
    check("ch1 wb_rd", wb_rd, 11);
    check("ch1 stall done", stall, 0);

    // Unmapped load faults without a request.
    set_op(DMEM_LW, 32'h8000_0000, 32'h0, 32'h0, 5'd4, 1'b1);
    dmem_gnt = 1'b1;
    #1;
    check("unm dmem_req", dmem_req, 0);
    check("unm periph_req", periph_req, 0);
    check("unm stall", stall, 0);
    tick();
    ex_idle();
    dmem_gnt = 1'b0;
    check("unm fault", fault, 1);
    check("unm fault_addr", fault_addr, 32'h8000_0000);
    check("unm wb_valid", wb_valid, 0);
    tick();
    check("unm fault pulse", fault, 0);
    check("unm fault_addr held", fault_addr, 32'h8000_0000);

    // Word load at 0x2.
`ifdef LSU_MISALIGN_TRAP_EN
    set_op(DMEM_LW, 32'h2, 32'h0, 32'h0, 5'd4, 1'b1);
    dmem_gnt = 1'b1;
    #1;
    check("mis req", dmem_req, 0);
    check("mis stall", stall, 0);
    tick();
    ex_idle();
    dmem_gnt = 1'b0;
    check("mis fault", fault, 1);
    check("mis fault_addr", fault_addr, 32'h2);
    check("mis wb_valid", wb_valid, 0);
`else
    dmem_load("lw_unaligned", DMEM_LW, 32'h2, 32'h0102_0304, 32'h0102_0304);
    check("unaligned no fault", fault, 0);
`endif

    // Flush in IDLE suppresses request and writeback.
    set_op(DMEM_LW, 32'h20, 32'h0, 32'h0, 5'd5, 1'b1);
    dmem_gnt = 1'b1; flush = 1'b1;
    #1;
    check("flush idle req", dmem_req, 0);
    check("flush idle stall", stall, 0);
    tick();
    ex_idle();
    dmem_gnt = 1'b0; flush = 1'b0;
    check("flush idle wb", wb_valid, 0);
    check("flush idle fault", fault, 0);

    // Flush during WAIT: response consumed, no writeback.
    set_op(DMEM_LW, 32'h24, 32'h0, 32'h0, 5'd12, 1'b1);
    dmem_gnt = 1'b1;
    #1;
    check("fw req", dmem_req, 1);
    tick();
    ex_idle();
    dmem_gnt = 1'b0; flush = 1'b1;
    #1;
    check("fw stall", stall, 1);
    tick();
    flush = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    #1;
    check("fw stall at rvalid", stall, 1);
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    check("fw wb_valid", wb_valid, 0);
    check("fw stall done", stall, 0);
    dmem_load("after_flush", DMEM_LW, 32'h28, 32'h1357_9BDF, 32'h1357_9BDF);

    // Flush and grant together in REQ: flush wins.
    set_op(DMEM_SW, 32'h30, 32'h5555_AAAA, 32'h0, 5'd0, 1'b0);
    #1;
    check("fr stall", stall, 1);
    tick();
    ex_idle();
    flush = 1'b1; dmem_gnt = 1'b1;
    #1;
    check("fr req withdrawn", dmem_req, 0);
    tick();
    flush = 1'b0; dmem_gnt = 1'b0;
    #1;
    check("fr stall after", stall, 0);
    check("fr wb_valid", wb_valid, 0);

    // Reset while in REQ.
    set_op(DMEM_SW, 32'h40, 32'hA5A5_A5A5, 32'h0, 5'd0, 1'b0);
    #1;
    tick();
    ex_idle();
    #1;
    check("rr req held", dmem_req, 1);
    resetn = 1'b0;
    tick();
    check("rr req", dmem_req, 0);
    check("rr we", dmem_we, 0);
    check("rr be", dmem_be, 0);
    check("rr stall", stall, 0);
    check("rr wb_valid", wb_valid, 0);
    check("rr fault_addr", fault_addr, 0);
    resetn = 1'b1;
    #1;
    check("rr idle after release", dmem_req, 0);
    check("rr stall after release", stall, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
